data_mem_ws: RTL

DATA_MEM_WS -- requirements
Module: data_mem_ws

---
 rtl/data_mem_ws.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_ws.sv
// data_mem_ws
//
// Word-organised data memory with a fixed number of wait states per access.
// Every request is captured when the FSM leaves IDLE, the FSM then sits in WAIT
// for WAIT_CYCLES cycles, and the access itself (array write or read-data
// update) happens on the edge that enters DONE. DONE lasts one cycle, then the
// FSM returns to IDLE.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, 4..1024)
//   WAIT_CYCLES  wait-state cycles per access (0..15)
//
// Ports
//   clk       single rising-edge clock
//   rst       synchronous active-high reset; clears state, out, err and the whole array
//   MEM_R_EN  read request, held until ready=1
//   MEM_W_EN  write request, held until ready=1 (wins over MEM_R_EN)
//   Address   byte address; [1:0] byte offset, [log2(DEPTH)+1:2] word index
//   val_Rm    write data, right-justified for byte and halfword sizes
//   SIZE      00 byte, 01 halfword, 10/11 word
//   out       registered read data, zero-extended; holds until the next completed read
//   ready     high when idle without a request, or in DONE
//   err       high only in DONE for a misaligned or out-of-range access

module data_mem_ws #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] Address,
    input  logic [31:0] val_Rm,
    input  logic [1:0]  SIZE,
    output logic [31:0] out,
    output logic        ready,
    output logic        err
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic [31:0] out_q, out_d;
    logic        err_q, err_d;
    logic        memWe;

    logic [31:0] mem_q [DEPTH];

    logic        req;
    logic [31:0] txnAddr;
    logic [31:0] txnData;
    logic [1:0]  txnSize;
    logic        txnWrite;
    logic [IDX_W-1:0] txnIdx;
    logic        outOfRange;
    logic        misaligned;
    logic        accessErr;
    logic [31:0] curWord;
    logic [3:0]  laneEn;
    logic [31:0] wrWord;
    logic [31:0] mergedWord;
    logic [31:0] rdVal;

    assign req = MEM_R_EN | MEM_W_EN;

    // While reset is held the FSM is treated as IDLE for the ready output.
    assign ready = (rst || state_q == IDLE) ? ~req : (state_q == DONE);
    assign out   = out_q;
    assign err   = err_q;

    // With zero wait states the access completes on the very edge that
    // captures the request, so the transaction is taken straight from the
    // inputs in IDLE; in every other state the captured copy is used.
    always_comb begin
        if (state_q == IDLE) begin
            txnAddr  = Address;
            txnData  = val_Rm;
            txnSize  = SIZE;
            txnWrite = MEM_W_EN;
        end else begin
            txnAddr  = addr_q;
            txnData  = data_q;
            txnSize  = size_q;
            txnWrite = write_q;
        end
    end

    assign txnIdx     = txnAddr[IDX_W+1:2];
    assign outOfRange = (txnAddr >= 32'(4 * DEPTH));
    assign misaligned = ((txnSize == 2'b01) && txnAddr[0]) ||
                        (txnSize[1] && (txnAddr[1:0] != 2'b00));
    assign accessErr  = outOfRange | misaligned;
    assign curWord    = mem_q[txnIdx];

    // Lane enables, replicated write data and the zero-extended read value
    // for the current transaction (little-endian lane numbering).
    always_comb begin
        laneEn = 4'b0000;
        wrWord = '0;
        rdVal  = '0;
        case (txnSize)
            2'b00: begin
                laneEn[txnAddr[1:0]] = 1'b1;
                wrWord = {4{txnData[7:0]}};
                rdVal  = (curWord >> {txnAddr[1:0], 3'b000}) & 32'h0000_00FF;
            end
            2'b01: begin
                laneEn = txnAddr[1] ? 4'b1100 : 4'b0011;
                wrWord = {2{txnData[15:0]}};
                rdVal  = (curWord >> {txnAddr[1], 4'b0000}) & 32'h0000_FFFF;
            end
            default: begin
                laneEn = 4'b1111;
                wrWord = txnData;
                rdVal  = curWord;
            end
        endcase
    end

    // Lanes not being written keep their old contents.
    always_comb begin
        mergedWord = curWord;
        for (int i = 0; i < 4; i++) begin
            if (laneEn[i]) begin
                mergedWord[8*i +: 8] = wrWord[8*i +: 8];
            end
        end
    end

    // Next-state logic; the access takes effect on whichever edge enters DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        write_d = write_q;
        out_d   = out_q;
        err_d   = 1'b0;
        memWe   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = Address;
                    data_d  = val_Rm;
                    size_d  = SIZE;
                    write_d = MEM_W_EN;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == DONE) begin
            err_d = accessErr;
            memWe = txnWrite & ~accessErr;
            if (!txnWrite) begin
                out_d = accessErr ? 32'h0 : rdVal;
            end
        end
    end

    // Control and transaction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= 2'b00;
            write_q <= 1'b0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            write_q <= write_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    // Storage array; reset clears every word, which also aborts any write in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (memWe) begin
            mem_q[txnIdx] <= mergedWord;
        end
    end

endmodule
